// File: rtl/dec_conv_arbiter_pkg.sv
// Shared types and helpers for the two-requester decimal converter arbiter.
package dec_conv_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SET  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int SEG_W = 7;

   // Wait counter must hold CONV_LAT-1; never narrower than one bit.
   function automatic int cnt_width(input int lat);
      if (lat <= 2) begin
         return 1;
      end else begin
         return $clog2(lat);
      end
   endfunction

endpackage

// File: rtl/dec_conv_arbiter_rr.sv
// Two-input round-robin picker: ptr names the requester preferred on a tie.
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic gnt_valid,
   output logic gnt_idx
);

   // Grant selection: single requester wins outright, tie goes to ptr.
   always_comb begin
      gnt_valid = req0 | req1;
      if (req0 && req1) begin
         gnt_idx = ptr;
      end else if (req1) begin
         gnt_idx = 1'b1;
      end else begin
         gnt_idx = 1'b0;
      end
   end

endmodule

// File: rtl/dec_conv_arbiter.sv
// Shares one binary-to-7-seg converter between two level requesters:
// grant, set pulse, fixed latency wait, capture, done pulse to the owner.
module dec_conv_arbiter
   import dec_conv_arbiter_pkg::*;
#(
   parameter int WIDTH    = 7,
   parameter int CONV_LAT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             done0,
   output logic             done1,
   output logic [SEG_W-1:0] res_hi,
   output logic [SEG_W-1:0] res_lo,
   output logic             res_ovf,
   output logic             busy,
   output logic             conv_rst,
   output logic             conv_set,
   output logic [WIDTH-1:0] conv_bin,
   input  logic [SEG_W-1:0] conv_hi,
   input  logic [SEG_W-1:0] conv_lo,
   input  logic             conv_ovf
);

   localparam int               CNT_W    = cnt_width(CONV_LAT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_t             state_r;
   state_t             state_s;
   logic               ptr_r;
   logic               owner_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               gnt_valid_s;
   logic               gnt_idx_s;
   logic [WIDTH-1:0]   conv_bin_r;
   logic [SEG_W-1:0]   res_hi_r;
   logic [SEG_W-1:0]   res_lo_r;
   logic               res_ovf_r;
   logic               done0_r;
   logic               done1_r;
   logic               conv_set_r;
   logic               busy_r;

   rr_arb2 u_arb (
      .req0      (req0),
      .req1      (req1),
      .ptr       (ptr_r),
      .gnt_valid (gnt_valid_s),
      .gnt_idx   (gnt_idx_s)
   );

   // Next-state decode; requests only matter while idle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (gnt_valid_s) begin
               state_s = SET;
            end else begin
               state_s = IDLE;
            end
         end
         SET:  state_s = WAIT;
         WAIT: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = DONE;
            end else begin
               state_s = WAIT;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register and pulse outputs, decoded one cycle ahead so they are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         busy_r     <= 1'b0;
         conv_set_r <= 1'b0;
         done0_r    <= 1'b0;
         done1_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         busy_r     <= (state_s != IDLE);
         conv_set_r <= (state_s == SET);
         done0_r    <= (state_s == DONE) && !owner_r;
         done1_r    <= (state_s == DONE) && owner_r;
      end
   end

   // Ownership, operand, wait counter, result capture and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r      <= 1'b0;
         owner_r    <= 1'b0;
         cnt_r      <= CNT_ZERO;
         conv_bin_r <= {WIDTH{1'b0}};
         res_hi_r   <= {SEG_W{1'b0}};
         res_lo_r   <= {SEG_W{1'b0}};
         res_ovf_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (gnt_valid_s) begin
                  owner_r    <= gnt_idx_s;
                  conv_bin_r <= gnt_idx_s ? data1 : data0;
               end
            end
            SET: cnt_r <= CNT_LOAD;
            WAIT: begin
               if (cnt_r == CNT_ZERO) begin
                  res_hi_r  <= conv_hi;
                  res_lo_r  <= conv_lo;
                  res_ovf_r <= conv_ovf;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            DONE:    ptr_r <= ~owner_r;
            default: ptr_r <= ptr_r;
         endcase
      end
   end

   assign conv_rst = rst;
   assign conv_set = conv_set_r;
   assign conv_bin = conv_bin_r;
   assign busy     = busy_r;
   assign done0    = done0_r;
   assign done1    = done1_r;
   assign res_hi   = res_hi_r;
   assign res_lo   = res_lo_r;
   assign res_ovf  = res_ovf_r;

endmodule
